// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Ratio encoding: N <= 1 selects bypass, N >= 2 divides by N.
package clk_div_pkg;

    localparam int DIV_WIDTH_DEF = 8;

    typedef logic [DIV_WIDTH_DEF-1:0] div_t;

    function automatic logic is_bypass(input div_t d);
        return d <= div_t'(1);
    endfunction

    // Count threshold below which q_pos is high: N/2 for even N, (N+1)/2 for odd N.
    function automatic logic [DIV_WIDTH_DEF:0] high_cnt(input div_t d);
        return ({1'b0, d} + (DIV_WIDTH_DEF + 1)'(1)) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider counter with posedge/negedge phase flops; odd ratios AND the two
// phases so the high time is N/2 reference cycles.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 clk_n_i,
    input  logic                 rst_i,
    input  logic                 hold_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 period_end_o,
    output logic                 clk_o
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH:0]   high;
    logic                 q_pos;
    logic                 q_neg;

    assign high         = high_cnt(div_i);
    assign period_end_o = (cnt == div_i - ONE);

    // q_pos is registered from the current count, so the output rises one
    // cycle after the edge on which cnt returns to 0.
    always_ff @(posedge clk_i) begin
        if (rst_i || hold_i) begin
            cnt   <= '0;
            q_pos <= 1'b0;
        end else begin
            q_pos <= ({1'b0, cnt} < high);
            cnt   <= period_end_o ? '0 : cnt + ONE;
        end
    end

    always_ff @(posedge clk_n_i) begin
        if (rst_i) begin
            q_neg <= 1'b0;
        end else begin
            q_neg <= q_pos;
        end
    end

    assign clk_o = div_i[0] ? (q_pos & q_neg) : q_pos;

endmodule

// File: rtl/tc_clk_inv.sv
// Technology clock inverter cell (behavioural model).
module tc_clk_inv (
    input  logic clk_i,
    output logic clk_o
);

    assign clk_o = ~clk_i;

endmodule

// File: rtl/tc_clk_mux2.sv
// Technology glitch-safe 2:1 clock mux cell (behavioural model).
module tc_clk_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);

    assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: ratio handshake, period-boundary apply,
// enable gating and bypass selection around clk_div_core.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
    parameter int DEFAULT_DIV = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic [DIV_WIDTH-1:0] div_cur_o,
    output logic                 busy_o,
    output logic                 clk_o
);

    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);

    logic [DIV_WIDTH-1:0] div_cur;
    logic [DIV_WIDTH-1:0] pend_div;
    logic [DIV_WIDTH-1:0] div_next;
    logic                 ready;
    logic                 busy;
    logic                 run;
    logic                 run_next;
    logic                 sel;
    logic                 accept;
    logic                 apply;
    logic                 hold;
    logic                 period_end;
    logic                 clk_n;
    logic                 clk_div;

    assign accept   = div_valid_i & ready;
    // While stopped or bypassed there is no period to finish, so a pending
    // ratio applies on the very next edge.
    assign hold     = !run || is_bypass(div_cur);
    assign apply    = busy && (hold || period_end);
    assign div_next = apply ? pend_div : div_cur;

    always_comb begin
        run_next = run;
        if (hold || period_end) begin
            run_next = en_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cur <= DIV_RST;
            ready   <= 1'b1;
            busy    <= 1'b0;
            run     <= 1'b0;
            sel     <= 1'b0;
        end else begin
            div_cur <= div_next;
            run     <= run_next;
            sel     <= run_next && is_bypass(div_next);
            if (accept) begin
                busy  <= 1'b1;
                ready <= 1'b0;
            end else if (apply) begin
                busy  <= 1'b0;
                ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            pend_div <= div_i;
        end
    end

    tc_clk_inv u_clk_inv (
        .clk_i (clk_i),
        .clk_o (clk_n)
    );

    clk_div_core #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_core (
        .clk_i        (clk_i),
        .clk_n_i      (clk_n),
        .rst_i        (rst_i),
        .hold_i       (hold),
        .div_i        (div_cur),
        .period_end_o (period_end),
        .clk_o        (clk_div)
    );

    tc_clk_mux2 u_clk_mux (
        .clk0_i    (clk_div),
        .clk1_i    (clk_i),
        .clk_sel_i (sel),
        .clk_o     (clk_o)
    );

    assign div_ready_o = ready;
    assign busy_o      = busy;
    assign div_cur_o   = div_cur;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: output shape measured in half cycles
// from a sample history, against ratios tracked by a simple reference model.
module tb_clk_div_ctrl;

    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic [DW-1:0] div_i;
    logic          div_valid_i;
    logic          div_ready_o;
    logic [DW-1:0] div_cur_o;
    logic          busy_o;
    logic          clk_o;

    int checks = 0;
    int errors = 0;
    bit hist[$];
    bit clkq[$];
    int ref_cur;
    bit ref_en;

    typedef struct {
        int div;
        int per;
        int hi;
    } vec_t;
    vec_t tab[9];

    clk_div_ctrl #(.DIV_WIDTH(DW), .DEFAULT_DIV(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .div_cur_o   (div_cur_o),
        .busy_o      (busy_o),
        .clk_o       (clk_o)
    );

    always #5 clk_i = ~clk_i;

    // One sample of clk_o per half cycle, taken 1 ns after every clk_i edge.
    always @(clk_i) begin
        #1;
        hist.push_back(clk_o);
        clkq.push_back(clk_i);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_le(input string nm, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s actual %0d limit %0d", nm, act, lim);
        end
    endtask

    task automatic chk_ge(input string nm, input int act, input int lim);
        checks++;
        if (act < lim) begin
            errors++;
            $display("FAIL %s actual %0d minimum %0d", nm, act, lim);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    function automatic int next_rise(input int from);
        for (int i = from + 1; i < hist.size(); i++)
            if (hist[i] && !hist[i-1]) return i;
        return -1;
    endfunction

    function automatic int next_fall(input int from);
        for (int i = from + 1; i < hist.size(); i++)
            if (!hist[i] && hist[i-1]) return i;
        return -1;
    endfunction

    function automatic int prev_rise(input int from);
        for (int i = from; i > 0; i--)
            if (hist[i] && !hist[i-1]) return i;
        return -1;
    endfunction

    function automatic int min_run(input int a, input int b);
        int m = 1 << 30;
        int start = a;
        for (int i = a + 1; i <= b; i++) begin
            if (hist[i] != hist[i-1]) begin
                if (i - start < m) m = i - start;
                start = i;
            end
        end
        return m;
    endfunction

    function automatic int count_ones(input int from);
        int c = 0;
        for (int i = from; i < hist.size(); i++) c += int'(hist[i]);
        return c;
    endfunction

    // Period and high time (half cycles) of the first full pulse after 'from'.
    task automatic check_shape(input string nm, input int from, input int eper, input int ehi);
        int r1, f, r2;
        r1 = next_rise(from);
        f  = (r1 < 0) ? -1 : next_fall(r1);
        r2 = (r1 < 0) ? -1 : next_rise(r1);
        chk({nm, "_period"}, (r1 < 0 || r2 < 0) ? -1 : r2 - r1, eper);
        chk({nm, "_high"}, (r1 < 0 || f < 0) ? -1 : f - r1, ehi);
    endtask

    task automatic set_ratio(input int n, output int aidx, output int lat);
        int t = 0;
        int lim;
        while (!div_ready_o && t < 64) begin
            step(1);
            t++;
        end
        chk("ready_wait", int'(div_ready_o), 1);
        lim = (ref_cur <= 1 || !ref_en) ? 1 : ref_cur + 1;
        div_i       = DW'(n);
        div_valid_i = 1'b1;
        step(1);
        div_valid_i = 1'b0;
        chk("accept_busy", int'(busy_o), 1);
        chk("accept_ready", int'(div_ready_o), 0);
        lat = 0;
        while (busy_o && lat < 600) begin
            step(1);
            lat++;
        end
        aidx = hist.size() - 1;
        chk("apply_done", int'(busy_o), 0);
        chk_le("apply_latency", lat, lim);
        chk("apply_div_cur", int'(div_cur_o), n);
        ref_cur = n;
    endtask

    task automatic wait_rise();
        int t = 0;
        bit prev;
        prev = clk_o;
        step(1);
        while (!(clk_o && !prev) && t < 64) begin
            prev = clk_o;
            step(1);
            t++;
        end
        chk_le("rise_wait", t, 63);
    endtask

    initial begin
        int a, lat, s, r0, r1, r2, r3, mism, n, old;

        tab[0] = '{2, 4, 2};
        tab[1] = '{3, 6, 3};
        tab[2] = '{5, 10, 5};
        tab[3] = '{1, 2, 1};
        tab[4] = '{8, 16, 8};
        tab[5] = '{0, 2, 1};
        tab[6] = '{255, 510, 255};
        tab[7] = '{6, 12, 6};
        tab[8] = '{4, 8, 4};

        rst_i = 1'b1; en_i = 1'b1; div_valid_i = 1'b0; div_i = '0;
        ref_cur = 4; ref_en = 1'b1;

        // Reset behaviour with DEFAULT_DIV = 4
        @(posedge clk_i);
        #2;
        for (int i = 0; i < 4; i++) begin
            chk("rst_clk_low", int'(clk_o), 0);
            step(1);
        end
        chk("rst_hist_low", count_ones(0), 0);
        chk("rst_div_cur", int'(div_cur_o), 4);
        chk("rst_ready", int'(div_ready_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        rst_i = 1'b0;
        s = hist.size() - 1;
        step(16);
        check_shape("default4", s, 8, 4);

        // Table of ratios, each measured after it is applied
        for (int i = 0; i < 9; i++) begin
            set_ratio(tab[i].div, a, lat);
            step(2 * ((tab[i].div < 2) ? 1 : tab[i].div) + 8);
            check_shape($sformatf("tab%0d", tab[i].div), a, tab[i].per, tab[i].hi);
        end

        // 4 -> 6 accepted at cnt = 1: current period completes first
        wait_rise();
        set_ratio(6, a, lat);
        step(16);
        r0 = prev_rise(a);
        r1 = next_rise(a);
        r2 = (r1 < 0) ? -1 : next_rise(r1);
        if (r0 < 0 || r1 < 0 || r2 < 0) begin
            chk("chg_edges_found", 0, 1);
        end else begin
            chk("chg_old_period", r1 - r0, 8);
            chk("chg_new_period", r2 - r1, 12);
            chk_ge("chg_min_run", min_run(r0, r2), 4);
        end

        // Bypass round trip
        set_ratio(4, a, lat);
        set_ratio(1, a, lat);
        step(8);
        mism = 0;
        for (int i = a; i < a + 12; i++) if (hist[i] != clkq[i]) mism++;
        chk("byp_follow", mism, 0);
        set_ratio(3, a, lat);
        chk("byp_to_div_latency", lat, 1);
        step(14);
        check_shape("byp_first3", a, 6, 3);
        r1 = next_rise(a);
        r3 = (r1 < 0) ? -1 : next_rise(next_rise(r1));
        if (r1 < 0 || r3 < 0) chk("byp_edges_found", 0, 1);
        else chk("byp_first_runs", min_run(r1, r3), 3);

        // Enable: stop at period end, accept while stopped, restart
        set_ratio(4, a, lat);
        wait_rise();
        en_i = 1'b0; ref_en = 1'b0;
        step(4);
        s = hist.size();
        r0 = prev_rise(s - 1);
        chk("en_last_high", (r0 < 0) ? -1 : next_fall(r0) - r0, 4);
        step(20);
        set_ratio(6, a, lat);
        chk("dis_apply_latency", lat, 1);
        step(3);
        chk("en_stopped_low", count_ones(s), 0);
        s = hist.size() - 1;
        en_i = 1'b1; ref_en = 1'b1;
        step(1);
        chk("restart_low", int'(clk_o), 0);
        step(1);
        chk("restart_rise", int'(clk_o), 1);
        step(14);
        check_shape("restart6", s, 12, 6);

        // Reset with a pending request of 7 at N = 4
        set_ratio(4, a, lat);
        wait_rise();
        div_i = DW'(7);
        div_valid_i = 1'b1;
        step(1);
        div_valid_i = 1'b0;
        chk("rm_pending", int'(busy_o), 1);
        rst_i = 1'b1;
        step(1);
        chk("rm_clk_low", int'(clk_o), 0);
        chk("rm_div_cur", int'(div_cur_o), 4);
        chk("rm_busy", int'(busy_o), 0);
        chk("rm_ready", int'(div_ready_o), 1);
        rst_i = 1'b0;
        ref_cur = 4;
        s = hist.size() - 1;
        step(20);
        chk("rm_not_applied", int'(div_cur_o), 4);
        chk("rm_busy_after", int'(busy_o), 0);
        check_shape("rm_period", s, 8, 4);

        // Random ratio changes at random phases against the ratio model
        for (int it = 0; it < 24; it++) begin
            n = int'($urandom_range(0, 10));
            step(int'($urandom_range(0, 9)));
            old = ref_cur;
            set_ratio(n, a, lat);
            step(2 * ((n < 2) ? 1 : n) + 8);
            check_shape($sformatf("rnd%0d_n%0d", it, n), a,
                        (n < 2) ? 2 : 2 * n, (n < 2) ? 1 : n);
            if (old >= 2 && n >= 2 && (old % 2) == (n % 2)) begin
                r0 = prev_rise(a);
                r1 = next_rise(a);
                chk($sformatf("rnd%0d_boundary", it),
                    (r0 < 0 || r1 < 0) ? -1 : r1 - r0, 2 * old);
            end
        end

        rst_i = 1'b1;
        step(1);
        chk("final_rst_div_cur", int'(div_cur_o), 4);
        chk("final_rst_clk_low", int'(clk_o), 0);
        rst_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
